nested_loop_counter: RTL and testbench

Parametrised multi-level loop counter that generates nested loop indices (e.g. output neuron / input neuron / kernel position) for the dense and convolution datapaths. Level 0 is the innermost loop and advances on each enabled cycle. Each outer level advances when every inner level wraps. A start/busy/done handshake frames one complete pass through all levels, so controllers no longer need to chain single-level counters by hand.

---
 rtl/nested_loop_counter.sv | 112 +++++++++++
 tb/tb_nested_loop_counter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/nested_loop_counter.sv
// Multi-level nested loop index generator with start/busy/done framing.
// Define NLC_PROG_LIMITS_EN to load per-level limits from the limits port on start.
module nested_loop_counter #(
  parameter int LEVELS = 3,
  parameter int WIDTH = 4,
  parameter logic [LEVELS*WIDTH-1:0] STOPS = {4'd10, 4'd10, 4'd10}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    en,
  input  logic                    clr,
  input  logic [LEVELS*WIDTH-1:0] limits,
  output logic                    busy,
  output logic [LEVELS*WIDTH-1:0] cnt,
  output logic [LEVELS-1:0]       co,
  output logic                    last,
  output logic                    done
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [0:0]              state_reg;
  logic [LEVELS*WIDTH-1:0] cnt_reg;
  logic [LEVELS*WIDTH-1:0] cnt_next;
  logic [LEVELS*WIDTH-1:0] lim;
  logic [LEVELS-1:0]       at_top;
  logic [LEVELS-1:0]       adv;
  logic                    done_reg;
  logic                    run;

  assign run = (state_reg == S_RUN);

`ifdef NLC_PROG_LIMITS_EN
  logic [LEVELS*WIDTH-1:0] lim_reg;

  // Limits are captured only when a start is actually accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lim_reg <= STOPS;
    end else if (!clr && !run && start) begin
      lim_reg <= limits;
    end
  end

  assign lim = lim_reg;
`else
  logic unused_limits;
  assign unused_limits = ^limits;
  assign lim = STOPS;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < LEVELS; gi++) begin : g_level
      logic [WIDTH-1:0] lim_i;
      logic [WIDTH-1:0] top_i;
      logic [WIDTH-1:0] cnt_i;

      assign lim_i = lim[gi*WIDTH +: WIDTH];
      assign cnt_i = cnt_reg[gi*WIDTH +: WIDTH];
      // A zero limit behaves as one iteration: the level sits at 0 and always wraps.
      assign top_i = (lim_i == '0) ? '0 : lim_i - ONE;
      assign at_top[gi] = (cnt_i == top_i);

      if (gi == 0) begin : g_first
        assign adv[gi] = en & run;
      end else begin : g_outer
        assign adv[gi] = en & run & (&at_top[gi-1:0]);
      end

      assign co[gi] = adv[gi] & at_top[gi];
      assign cnt_next[gi*WIDTH +: WIDTH] = !adv[gi] ? cnt_i :
                                           (at_top[gi] ? '0 : cnt_i + ONE);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else if (clr) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (state_reg == S_IDLE) begin
        cnt_reg <= '0;
        if (start) begin
          state_reg <= S_RUN;
        end
      end else begin
        // On the final edge every level is at its top, so cnt_next is all zeros.
        cnt_reg <= cnt_next;
        if (last) begin
          state_reg <= S_IDLE;
          done_reg  <= 1'b1;
        end
      end
    end
  end

  assign last = co[LEVELS-1];
  assign busy = run;
  assign cnt  = cnt_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_nested_loop_counter.sv
// Self-checking bench for nested_loop_counter: explicit vector table plus a
// mixed-radix reference model feeding a scoreboard queue.
module tb_nested_loop_counter;
  localparam int L = 3;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic [L*W-1:0] limits = {4'd10, 4'd10, 4'd10};
  logic busy, last, done;
  logic [L*W-1:0] cnt;
  logic [L-1:0] co;

  nested_loop_counter #(.LEVELS(L), .WIDTH(W), .STOPS({4'd10, 4'd10, 4'd10})) dut (
    .clk(clk), .rst(rst), .start(start), .en(en), .clr(clr), .limits(limits),
    .busy(busy), .cnt(cnt), .co(co), .last(last), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic busy; logic [L*W-1:0] cnt; logic done; logic [L-1:0] co; logic last;
  } exp_t;

  typedef struct {
    logic r; logic s; logic e; logic c;
    logic busy; logic [L*W-1:0] cnt; logic done; logic [L-1:0] co; logic last;
  } vec_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_miss = 0;

  // Drive one cycle, sample combinational outputs before the edge and
  // registered outputs just after it, then compare against the queued record.
  task automatic apply(input logic r, input logic s, input logic e, input logic c,
                       input exp_t x, input string tag);
    logic [L-1:0] co_s;
    logic last_s;
    exp_t g;
    @(negedge clk);
    rst = r; start = s; en = e; clr = c;
    sb.push_back(x);
    #1;
    co_s = co;
    last_s = last;
    @(posedge clk);
    #1;
    g = sb.pop_front();
    n_vec++;
    if (co_s !== g.co) begin
      n_miss++; $display("FAIL %s #%0d co got %b want %b", tag, n_vec, co_s, g.co);
    end
    if (last_s !== g.last) begin
      n_miss++; $display("FAIL %s #%0d last got %b want %b", tag, n_vec, last_s, g.last);
    end
    if (busy !== g.busy) begin
      n_miss++; $display("FAIL %s #%0d busy got %b want %b", tag, n_vec, busy, g.busy);
    end
    if (cnt !== g.cnt) begin
      n_miss++; $display("FAIL %s #%0d cnt got %h want %h", tag, n_vec, cnt, g.cnt);
    end
    if (done !== g.done) begin
      n_miss++; $display("FAIL %s #%0d done got %b want %b", tag, n_vec, done, g.done);
    end
  endtask

  // Reference model: the pass is a count m_n of enabled cycles, indices are its
  // mixed-radix digits, and a level carries when (m_n+1) is a multiple of the
  // product of effective limits up to that level.
  int m_lim[L];
  bit m_run = 1'b0;
  int m_n = 0;
  bit m_done = 1'b0;

  function automatic int eff(int i);
    return (m_lim[i] == 0) ? 1 : m_lim[i];
  endfunction

  function automatic int span(int i);
    int p = 1;
    for (int j = 0; j <= i; j++) p = p * eff(j);
    return p;
  endfunction

  task automatic mstep(input logic r, input logic s, input logic e, input logic c,
                       input string tag);
    exp_t x;
    bit lst;
    for (int i = 0; i < L; i++) x.co[i] = m_run && e && (((m_n + 1) % span(i)) == 0);
    lst = x.co[L-1];
    x.last = lst;
    if (!r) begin
      m_run = 1'b0; m_n = 0; m_done = 1'b0;
      for (int i = 0; i < L; i++) m_lim[i] = 10;
    end else if (c) begin
      m_run = 1'b0; m_n = 0; m_done = 1'b0;
    end else begin
      m_done = m_run && lst;
      if (!m_run) begin
        if (s) begin
          m_run = 1'b1;
          m_n = 0;
`ifdef NLC_PROG_LIMITS_EN
          for (int i = 0; i < L; i++) m_lim[i] = int'(limits[i*W +: W]);
`endif
        end
      end else if (e) begin
        if (lst) begin
          m_run = 1'b0; m_n = 0;
        end else begin
          m_n++;
        end
      end
    end
    x.busy = m_run;
    x.done = m_done;
    for (int i = 0; i < L; i++)
      x.cnt[i*W +: W] = W'((m_n / ((i == 0) ? 1 : span(i - 1))) % eff(i));
    apply(r, s, e, c, x, tag);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout after %0d vectors", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    exp_t x;
    int k;

    //        r     s     e     c     busy  cnt      done  co      last
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 3'b000, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 3'b000, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h001, 1'b0, 3'b000, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 12'h001, 1'b0, 3'b000, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h002, 1'b0, 3'b000, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'h003, 1'b0, 3'b000, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 3'b000, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 3'b000, 1'b0};

    for (int i = 0; i < L; i++) m_lim[i] = 10;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 8; i++) begin
      x.busy = tbl[i].busy; x.cnt = tbl[i].cnt; x.done = tbl[i].done;
      x.co = tbl[i].co; x.last = tbl[i].last;
      apply(tbl[i].r, tbl[i].s, tbl[i].e, tbl[i].c, x, "table");
    end

    // Full default pass with en held high, then start in the done cycle.
    mstep(1'b0, 1'b0, 1'b0, 1'b0, "reset");
    mstep(1'b1, 1'b1, 1'b0, 1'b0, "start");
    for (int i = 0; i < 1000; i++) mstep(1'b1, 1'b0, 1'b1, 1'b0, "pass1000");
    mstep(1'b1, 1'b1, 1'b0, 1'b0, "start_in_done");

    // clr at indices {1,1,2}, with gaps in en.
    k = 0;
    while (m_n != 112) begin
      mstep(1'b1, 1'b0, (k % 3) != 2, 1'b0, "to_112");
      k++;
    end
    mstep(1'b1, 1'b0, 1'b1, 1'b1, "clr_mid");
    mstep(1'b1, 1'b0, 1'b0, 1'b0, "after_clr");

    // Same abort via reset.
    mstep(1'b1, 1'b1, 1'b0, 1'b0, "start2");
    while (m_n != 112) mstep(1'b1, 1'b0, 1'b1, 1'b0, "to_112b");
    mstep(1'b0, 1'b0, 1'b1, 1'b0, "rst_mid");
    mstep(1'b1, 1'b0, 1'b0, 1'b0, "after_rst");

    // clr coinciding with last.
    mstep(1'b1, 1'b1, 1'b0, 1'b0, "start3");
    for (int i = 0; i < 999; i++) mstep(1'b1, 1'b0, 1'b1, 1'b0, "to_last");
    mstep(1'b1, 1'b0, 1'b1, 1'b1, "clr_last");
    mstep(1'b1, 1'b0, 1'b0, 1'b0, "no_done");

`ifdef NLC_PROG_LIMITS_EN
    limits = {4'd3, 4'd2, 4'd4};
    mstep(1'b1, 1'b1, 1'b0, 1'b0, "prog_start");
    for (int i = 0; i < 47; i++) begin
      if (i == 10) limits = 12'hfff;
      mstep(1'b1, 1'b0, (i % 2) == 0, 1'b0, "prog_324");
    end
    limits = {4'd2, 4'd0, 4'd3};
    mstep(1'b1, 1'b1, 1'b0, 1'b0, "prog_done_start");
    for (int i = 0; i < 12; i++) mstep(1'b1, 1'b0, (i % 2) == 0, 1'b0, "prog_203");
    mstep(1'b1, 1'b0, 1'b0, 1'b0, "prog_203_done");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
